// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and the sequence-detector family.
package seq_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_t;

    // Reference pattern of the "101" Moore detector driven by bit_out
    localparam int unsigned DET_PAT_LEN = 3;
    localparam logic [2:0]  DET_PATTERN = 3'b101;

    // Moore detector state encodings (non-overlapping "101")
    localparam logic [1:0] DET_S0   = 2'd0;
    localparam logic [1:0] DET_S1   = 2'd1;
    localparam logic [1:0] DET_S10  = 2'd2;
    localparam logic [1:0] DET_S101 = 2'd3;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Parallel word handshake into the pattern transmitter.
interface seq_pattern_tx_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;

    modport master (output in_valid, output in_data, output in_len, input  in_ready);
    modport slave  (input  in_valid, input  in_data, input  in_len, output in_ready);
endinterface

// File: rtl/bit_tick_div.sv
// Bit-period divider: counts DIV-1 down to 0 while enabled, ticking on the last clock of a period.
module bit_tick_div #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_c,
    output logic pre_tick_c
);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on clear or at period end, otherwise count down
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_LOAD;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? CNT_LOAD : cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= CNT_LOAD;
        else     cnt_q <= cnt_d;
    end

    assign tick_c     = en && (cnt_q == '0);
    // Next clock is the last of the period; never true when each period is one clock
    assign pre_tick_c = (DIV > 1) && en && (cnt_q == CNT_W'(1));
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a word, shifts its low len bits out MSB-first, then idles GAP bit-periods.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned DIV   = 1,
    parameter int unsigned GAP   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_pattern_tx_if.slave       in_if,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  busy,
    output logic                  done
);
    localparam logic [1:0] S_IDLE = TX_IDLE;
    localparam logic [1:0] S_SEND = TX_SEND;
    localparam logic [1:0] S_GAP  = TX_GAP;
    localparam logic [1:0] S_AFTER = (GAP > 0) ? S_GAP : S_IDLE;

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] shift_q,   shift_d;
    logic [LEN_W-1:0] idx_q,     idx_d;
    logic [GAP_W-1:0] gap_q,     gap_d;
    logic             bit_out_q, bit_out_d;
    logic             done_q,    done_d;

    logic [LEN_W-1:0] len_eff_c;
    logic [WIDTH-1:0] shifted_c;
    logic             accept_c;
    logic             tick_c;
    logic             pre_tick_c;
    logic             div_clr_c;
    logic             div_en_c;

    assign div_clr_c = (state_q == S_IDLE);
    assign div_en_c  = (state_q != S_IDLE);

    bit_tick_div #(.DIV(DIV)) u_div (
        .clk        (clk),
        .rst        (rst),
        .clr        (div_clr_c),
        .en         (div_en_c),
        .tick_c     (tick_c),
        .pre_tick_c (pre_tick_c)
    );

    // Next-state, shift register and done pulse
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        bit_out_d = bit_out_q;
        done_d    = 1'b0;

        len_eff_c = (in_if.in_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : in_if.in_len;
        accept_c  = in_if.in_valid && in_if.in_ready;
        shifted_c = shift_q << 1;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    gap_d = GAP_LOAD;
                    if (len_eff_c == '0) begin
                        done_d    = 1'b1;
                        bit_out_d = 1'b0;
                        state_d   = S_AFTER;
                    end else begin
                        // MSB-align the live bits so the current bit is always the top one
                        shift_d   = in_if.in_data << (LEN_W'(WIDTH) - len_eff_c);
                        bit_out_d = shift_d[WIDTH-1];
                        idx_d     = len_eff_c - LEN_W'(1);
                        done_d    = (len_eff_c == LEN_W'(1)) && (DIV == 1);
                        state_d   = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (tick_c) begin
                    if (idx_q == '0) begin
                        bit_out_d = 1'b0;
                        gap_d     = GAP_LOAD;
                        state_d   = S_AFTER;
                    end else begin
                        shift_d   = shifted_c;
                        bit_out_d = shifted_c[WIDTH-1];
                        idx_d     = idx_q - LEN_W'(1);
                        done_d    = (idx_q == LEN_W'(1)) && (DIV == 1);
                    end
                end else begin
                    done_d = (idx_q == '0) && pre_tick_c;
                end
            end
            S_GAP: begin
                bit_out_d = 1'b0;
                if (tick_c) begin
                    if (gap_q == '0) state_d = S_IDLE;
                    else             gap_d   = gap_q - GAP_W'(1);
                end
            end
            default: begin
                bit_out_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            bit_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            bit_out_q <= bit_out_d;
            done_q    <= done_d;
        end
    end

    assign in_if.in_ready = (state_q == S_IDLE) && !rst;
    assign bit_out        = bit_out_q;
    assign bit_valid      = (state_q == S_SEND);
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx across three parameter sets plus a "101" detector model.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] bo, bv, by, dn;

    int pass_cnt = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    // Instance 0: DIV=1 GAP=0, instance 1: DIV=3 GAP=0, instance 2: DIV=1 GAP=2
    seq_pattern_tx_if #(.WIDTH(8), .LEN_W(4)) if_a ();
    seq_pattern_tx_if #(.WIDTH(8), .LEN_W(4)) if_b ();
    seq_pattern_tx_if #(.WIDTH(8), .LEN_W(4)) if_c ();

    seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .DIV(1), .GAP(0)) dut_a (
        .clk(clk), .rst(rst), .in_if(if_a),
        .bit_out(bo[0]), .bit_valid(bv[0]), .busy(by[0]), .done(dn[0]));
    seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .DIV(3), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .in_if(if_b),
        .bit_out(bo[1]), .bit_valid(bv[1]), .busy(by[1]), .done(dn[1]));
    seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .DIV(1), .GAP(2)) dut_c (
        .clk(clk), .rst(rst), .in_if(if_c),
        .bit_out(bo[2]), .bit_valid(bv[2]), .busy(by[2]), .done(dn[2]));

    // Non-overlapping Moore "101" detector fed from instance 0
    logic       det_clr;
    logic [1:0] det_st;
    int         det_hits;
    logic       det_z;
    assign det_z = (det_st == DET_S101);

    always_ff @(posedge clk) begin
        if (det_clr) begin
            det_st   <= DET_S0;
            det_hits <= 0;
        end else begin
            case (det_st)
                DET_S0:  det_st <= bo[0] ? DET_S1 : DET_S0;
                DET_S1:  det_st <= bo[0] ? DET_S1 : DET_S10;
                DET_S10: begin
                    if (bo[0] == DET_PATTERN[0]) begin
                        det_st   <= DET_S101;
                        det_hits <= det_hits + 1;
                    end else begin
                        det_st <= DET_S0;
                    end
                end
                default: det_st <= bo[0] ? DET_S1 : DET_S0;
            endcase
        end
    end

    typedef struct packed {
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  len;
        logic [15:0] exp_bits;
        logic [4:0]  exp_n;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [1:0] s, input logic [7:0] d, input logic [3:0] l,
                                input logic [15:0] e, input logic [4:0] n);
        vec_t v;
        v.sel = s; v.data = d; v.len = l; v.exp_bits = e; v.exp_n = n;
        return v;
    endfunction

    function automatic int div_of(input int sel);
        return (sel == 1) ? 3 : 1;
    endfunction

    function automatic int gap_of(input int sel);
        return (sel == 2) ? 2 : 0;
    endfunction

    // {in_ready, busy, bit_valid, bit_out, done}
    function automatic logic [4:0] obs(input int sel);
        case (sel)
            0:       return {if_a.in_ready, by[0], bv[0], bo[0], dn[0]};
            1:       return {if_b.in_ready, by[1], bv[1], bo[1], dn[1]};
            default: return {if_c.in_ready, by[2], bv[2], bo[2], dn[2]};
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic [3:0] l);
        case (sel)
            0: begin if_a.in_valid = v; if_a.in_data = d; if_a.in_len = l; end
            1: begin if_b.in_valid = v; if_b.in_data = d; if_b.in_len = l; end
            default: begin if_c.in_valid = v; if_c.in_data = d; if_c.in_len = l; end
        endcase
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Offer one word, then compare every cycle until the block is idle again
    task automatic run_vec(input int id, input vec_t v);
        int sel, dv, s_cyc, g_cyc, n;
        logic [4:0] e;
        logic [15:0] eb;
        sel   = int'(v.sel);
        dv    = div_of(sel);
        n     = int'(v.exp_n);
        s_cyc = n * dv;
        g_cyc = gap_of(sel) * dv;
        eb    = v.exp_bits;
        @(negedge clk);
        chk($sformatf("vec%0d_ready_before", id), 16'(obs(sel)), 16'b10000);
        drive(sel, 1'b1, v.data, v.len);
        for (int i = 0; i <= s_cyc + g_cyc; i++) begin
            @(negedge clk);
            if (i == 0) drive(sel, 1'b0, ~v.data, v.len);
            if (i < s_cyc)
                e = {1'b0, 1'b1, 1'b1, eb[n - 1 - i / dv], 1'(i == s_cyc - 1)};
            else if (i < s_cyc + g_cyc)
                e = {1'b0, 1'b1, 1'b0, 1'b0, 1'((n == 0) && (i == 0))};
            else
                e = {1'b1, 1'b0, 1'b0, 1'b0, 1'((n == 0) && (i == 0))};
            chk($sformatf("vec%0d_cyc%0d", id, i), 16'(obs(sel)), 16'(e));
        end
    endtask

    initial begin
        logic [8:0] e_bo, e_rdy, e_z, e_dn;

        vecs[0] = mk(2'd0, 8'h05, 4'd3,  16'b101,       5'd3);  // basic 101
        vecs[1] = mk(2'd0, 8'hA5, 4'd8,  16'hA5,        5'd8);  // full width
        vecs[2] = mk(2'd0, 8'hC3, 4'd12, 16'hC3,        5'd8);  // len clipped to WIDTH
        vecs[3] = mk(2'd0, 8'hFF, 4'd0,  16'h0,         5'd0);  // empty word
        vecs[4] = mk(2'd0, 8'hF6, 4'd4,  16'b0110,      5'd4);  // upper bits ignored
        vecs[5] = mk(2'd1, 8'h02, 4'd2,  16'b10,        5'd2);  // DIV=3
        vecs[6] = mk(2'd1, 8'h0D, 4'd3,  16'b101,       5'd3);  // DIV=3
        vecs[7] = mk(2'd2, 8'h01, 4'd1,  16'b1,         5'd1);  // GAP=2
        vecs[8] = mk(2'd2, 8'h00, 4'd0,  16'h0,         5'd0);  // empty word then GAP

        rst = 1'b1;
        det_clr = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00, 4'd0);

        // Reset state: in_ready held low while rst is asserted
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk($sformatf("rst_hold%0d", s), 16'(obs(s)), 16'b00000);
        rst = 1'b0;
        det_clr = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) chk($sformatf("rst_rel%0d", s), 16'(obs(s)), 16'b10000);

        for (int k = 0; k < NVEC; k++) run_vec(k, vecs[k]);

        // Reset mid-word: word dropped, no done afterwards
        @(negedge clk);
        drive(0, 1'b1, 8'hA5, 4'd8);
        @(negedge clk);
        drive(0, 1'b0, 8'hA5, 4'd8);
        chk("mid_first_bit", 16'(obs(0)), 16'b01110);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst1", 16'(obs(0)), 16'b00000);
        @(negedge clk);
        chk("mid_rst2", 16'(obs(0)), 16'b00000);
        rst = 1'b0;
        #1;
        chk("mid_after", 16'(obs(0)), 16'b10000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("mid_quiet%0d", i), 16'(obs(0)), 16'b10000);
        end

        // Back-to-back 101,101 with in_valid held high
        @(negedge clk);
        det_clr = 1'b1;
        @(negedge clk);
        det_clr = 1'b0;
        e_bo  = 9'h055;
        e_rdy = 9'h188;
        e_z   = 9'h088;
        e_dn  = 9'h044;
        drive(0, 1'b1, 8'h05, 4'd3);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_bit%0d", i),   16'(bo[0]),         16'(e_bo[i]));
            chk($sformatf("b2b_rdy%0d", i),   16'(if_a.in_ready), 16'(e_rdy[i]));
            chk($sformatf("b2b_z%0d", i),     16'(det_z),         16'(e_z[i]));
            chk($sformatf("b2b_done%0d", i),  16'(dn[0]),         16'(e_dn[i]));
            if (i == 4) drive(0, 1'b0, 8'h05, 4'd3);
        end
        chk("b2b_hits", 16'(det_hits), 16'd2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
